// File: rtl/hazard_unit.sv
// hazard_unit: pipeline sequencing controller for the five-stage MIPS core.
// Drives PC / pipeline-register write enables and flushes, resolves data and
// instruction memory waits, load-use hazards, redirects and halt, and masks
// instruction-memory requests while a data access owns the shared port.
// Optional build macro HAZARD_PERF_EN adds stall_cnt / flush_cnt counters.
module hazard_unit (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       ihit,
    input  logic       dhit,
    input  logic       mem_dREN,
    input  logic       mem_dWEN,
    input  logic       ex_memread,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       ex_redirect,
    input  logic       id_jump,
    input  logic       wb_halt,
    output logic       pc_W,
    output logic       ifid_W,
    output logic       ifid_RST,
    output logic       idex_W,
    output logic       idex_RST,
    output logic       exmem_W,
    output logic       exmem_RST,
    output logic       memwb_W,
    output logic       memwb_RST,
    output logic       imem_mask,
    output logic       halt
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {RUN, DWAIT, HALTED} state_t;

    state_t state;

    logic memop, load_use;
    logic c_dmem, c_redir, c_lu, c_jump, c_imiss;
    logic pc_w_c, ifid_w_c, ifid_rst_c, idex_w_c, idex_rst_c;
    logic exmem_w_c, exmem_rst_c, memwb_w_c, memwb_rst_c, mask_c;

    assign memop    = mem_dREN | mem_dWEN;
    // r0 is never a real dependency, so a load into it cannot cause a stall
    assign load_use = ex_memread & (ex_rd != 5'd0) &
                      ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));

    // Priority decode of the hazard cases; exactly one (or none) is active
    always_comb begin
        c_dmem  = 1'b0;
        c_redir = 1'b0;
        c_lu    = 1'b0;
        c_jump  = 1'b0;
        c_imiss = 1'b0;
        if (state != HALTED) begin
            if (memop & ~dhit)   c_dmem  = 1'b1;
            else if (ex_redirect) c_redir = 1'b1;
            else if (load_use)    c_lu    = 1'b1;
            else if (id_jump)     c_jump  = 1'b1;
            else if (~ihit)       c_imiss = 1'b1;
        end
    end

    // Per-case enable/flush pattern; unnamed registers default to write, no flush
    always_comb begin
        pc_w_c      = 1'b1;
        ifid_w_c    = 1'b1;
        ifid_rst_c  = 1'b0;
        idex_w_c    = 1'b1;
        idex_rst_c  = 1'b0;
        exmem_w_c   = 1'b1;
        exmem_rst_c = 1'b0;
        memwb_w_c   = 1'b1;
        memwb_rst_c = 1'b0;
        mask_c      = 1'b0;
        if (state == HALTED) begin
            pc_w_c    = 1'b0;
            ifid_w_c  = 1'b0;
            idex_w_c  = 1'b0;
            exmem_w_c = 1'b0;
            memwb_w_c = 1'b0;
            mask_c    = 1'b1;
        end else if (c_dmem) begin
            // whole pipe freezes; fetch is kept off the shared memory port
            pc_w_c    = 1'b0;
            ifid_w_c  = 1'b0;
            idex_w_c  = 1'b0;
            exmem_w_c = 1'b0;
            memwb_w_c = 1'b0;
            mask_c    = 1'b1;
        end else if (c_redir) begin
            // ID and IF hold wrong-path instructions; the PC still loads even on a fetch miss
            ifid_rst_c = 1'b1;
            idex_rst_c = 1'b1;
        end else if (c_lu) begin
            // hold PC and IF/ID (no bubble on fetch miss), inject bubble into EX
            pc_w_c     = 1'b0;
            ifid_w_c   = 1'b0;
            idex_rst_c = 1'b1;
        end else if (c_jump) begin
            ifid_rst_c = 1'b1;
        end else if (c_imiss) begin
            pc_w_c     = 1'b0;
            ifid_rst_c = 1'b1;
        end
    end

    // All control outputs read as zero while reset is held
    assign pc_W      = nRST & pc_w_c;
    assign ifid_W    = nRST & ifid_w_c;
    assign ifid_RST  = nRST & ifid_rst_c;
    assign idex_W    = nRST & idex_w_c;
    assign idex_RST  = nRST & idex_rst_c;
    assign exmem_W   = nRST & exmem_w_c;
    assign exmem_RST = nRST & exmem_rst_c;
    assign memwb_W   = nRST & memwb_w_c;
    assign memwb_RST = nRST & memwb_rst_c;
    assign imem_mask = nRST & mask_c;

    // Sequencing FSM with registered halt flag
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= RUN;
            halt  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (wb_halt & memwb_w_c) begin
                        state <= HALTED;
                        halt  <= 1'b1;
                    end else if (memop & ~dhit) begin
                        state <= DWAIT;
                    end
                end
                DWAIT: begin
                    if (wb_halt & memwb_w_c) begin
                        state <= HALTED;
                        halt  <= 1'b1;
                    end else if (dhit) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= HALTED;
                    halt  <= 1'b1;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    // Stall and flush event counters; case decode is already empty in HALTED
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (c_dmem | c_lu | c_imiss) stall_cnt <= stall_cnt + 32'd1;
            if (c_redir | c_jump)        flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: the driver pushes hand-computed output
// vectors, a monitor pops and compares them on the falling clock edge.
module tb_hazard_unit;

    logic       CLK = 1'b1;
    logic       nRST;
    logic       ihit, dhit, mem_dREN, mem_dWEN, ex_memread;
    logic [4:0] ex_rd, id_rs, id_rt;
    logic       id_uses_rt, ex_redirect, id_jump, wb_halt;
    logic       pc_W, ifid_W, ifid_RST, idex_W, idex_RST;
    logic       exmem_W, exmem_RST, memwb_W, memwb_RST, imem_mask, halt;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    hazard_unit dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .ex_memread(ex_memread),
        .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_redirect(ex_redirect), .id_jump(id_jump), .wb_halt(wb_halt),
        .pc_W(pc_W), .ifid_W(ifid_W), .ifid_RST(ifid_RST),
        .idex_W(idex_W), .idex_RST(idex_RST), .exmem_W(exmem_W),
        .exmem_RST(exmem_RST), .memwb_W(memwb_W), .memwb_RST(memwb_RST),
        .imem_mask(imem_mask), .halt(halt)
`ifdef HAZARD_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    // {pc_W, ifid_W, ifid_RST, idex_W, idex_RST, exmem_W, exmem_RST, memwb_W, memwb_RST, imem_mask, halt}
    localparam logic [10:0] V_RESET  = 11'b0_00_00_00_00_0_0;
    localparam logic [10:0] V_RUN    = 11'b1_10_10_10_10_0_0;
    localparam logic [10:0] V_FREEZE = 11'b0_00_00_00_00_1_0;
    localparam logic [10:0] V_REDIR  = 11'b1_11_11_10_10_0_0;
    localparam logic [10:0] V_LU     = 11'b0_00_11_10_10_0_0;
    localparam logic [10:0] V_JUMP   = 11'b1_11_10_10_10_0_0;
    localparam logic [10:0] V_IMISS  = 11'b0_11_10_10_10_0_0;
    localparam logic [10:0] V_HALTED = 11'b0_00_00_00_00_1_1;

    typedef struct {
        logic [10:0] exp;
        string       name;
    } item_t;

    item_t sb[$];
    int    checks   = 0;
    int    failures = 0;

    // Monitor: one expected vector per cycle, compared mid-cycle
    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            item_t it;
            logic [10:0] act;
            it  = sb.pop_front();
            act = {pc_W, ifid_W, ifid_RST, idex_W, idex_RST, exmem_W,
                   exmem_RST, memwb_W, memwb_RST, imem_mask, halt};
            checks++;
            if (act !== it.exp) begin
                failures++;
                $display("FAIL %s: got %b expected %b", it.name, act, it.exp);
            end
        end
    end

    task automatic idle();
        ihit = 1'b1; dhit = 1'b0; mem_dREN = 1'b0; mem_dWEN = 1'b0;
        ex_memread = 1'b0; ex_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        id_uses_rt = 1'b0; ex_redirect = 1'b0; id_jump = 1'b0; wb_halt = 1'b0;
    endtask

    // Queue the expectation for the current inputs, then advance one cycle
    task automatic cyc(input logic [10:0] exp, input string nm);
        item_t it;
        it.exp  = exp;
        it.name = nm;
        sb.push_back(it);
        @(posedge CLK);
        #1;
    endtask

`ifdef HAZARD_PERF_EN
    task automatic chk_cnt(input logic [31:0] s, input logic [31:0] f, input string nm);
        checks++;
        if (stall_cnt !== s || flush_cnt !== f) begin
            failures++;
            $display("FAIL %s: stall_cnt=%0d flush_cnt=%0d expected %0d/%0d",
                     nm, stall_cnt, flush_cnt, s, f);
        end
    endtask
`endif

    initial begin
        nRST = 1'b0;
        idle();
        cyc(V_RESET, "reset_0");
        cyc(V_RESET, "reset_1");
        nRST = 1'b1;
        cyc(V_RUN, "run_idle");

        // data-memory wait of three cycles
        mem_dREN = 1'b1;
        cyc(V_FREEZE, "dwait_1");
        cyc(V_FREEZE, "dwait_2");
        cyc(V_FREEZE, "dwait_3");
        dhit = 1'b1;
        cyc(V_RUN, "dwait_hit");
        idle();
        cyc(V_RUN, "after_dwait");

        // store hitting on its first cycle
        mem_dWEN = 1'b1; dhit = 1'b1;
        cyc(V_RUN, "dhit_first");
        idle();

        // load-use on rs, rt, and non-hazards
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
        cyc(V_LU, "loaduse_rs");
        idle();
        cyc(V_RUN, "after_loaduse");
        ex_memread = 1'b1; ex_rd = 5'd7; id_rs = 5'd3; id_rt = 5'd7; id_uses_rt = 1'b1;
        cyc(V_LU, "loaduse_rt");
        id_uses_rt = 1'b0;
        cyc(V_RUN, "rt_unused");
        ex_rd = 5'd0; id_rs = 5'd0;
        cyc(V_RUN, "rd_zero");
        ex_rd = 5'd5; id_rs = 5'd5; ihit = 1'b0;
        cyc(V_LU, "loaduse_imiss");

        // redirect overrides load-use, jump and fetch miss
        ex_redirect = 1'b1; id_jump = 1'b1;
        cyc(V_REDIR, "redirect_combo");
        idle();
        id_jump = 1'b1;
        cyc(V_JUMP, "jump");
        ihit = 1'b0;
        cyc(V_JUMP, "jump_imiss");
        ihit = 1'b1; ex_memread = 1'b1; ex_rd = 5'd9; id_rs = 5'd9;
        cyc(V_LU, "loaduse_over_jump");
        idle();
        ihit = 1'b0;
        cyc(V_IMISS, "fetch_miss");
        idle();

        // data stall beats redirect; halt is ignored while MEM/WB is frozen
        mem_dREN = 1'b1; ex_redirect = 1'b1; wb_halt = 1'b1;
        cyc(V_FREEZE, "dmem_over_redirect");
        wb_halt = 1'b0; dhit = 1'b1;
        cyc(V_REDIR, "redirect_on_dhit");
        idle();
        cyc(V_RUN, "halt_masked");

        // halt and recovery by reset
        wb_halt = 1'b1;
        cyc(V_RUN, "halt_edge");
        wb_halt = 1'b0; ex_redirect = 1'b1;
        cyc(V_HALTED, "halted_1");
        ex_redirect = 1'b0; mem_dREN = 1'b1;
        cyc(V_HALTED, "halted_2");
        idle();
        nRST = 1'b0;
        cyc(V_RESET, "halt_reset");
        nRST = 1'b1;
        cyc(V_RUN, "resume");

`ifdef HAZARD_PERF_EN
        nRST = 1'b0;
        #2;
        chk_cnt(32'd0, 32'd0, "cnt_reset");
        nRST = 1'b1;
        @(posedge CLK); #1;
        mem_dREN = 1'b1;
        repeat (3) begin @(posedge CLK); #1; end
        dhit = 1'b1;
        @(posedge CLK); #1;
        idle();
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
        @(posedge CLK); #1;
        idle();
        ex_redirect = 1'b1;
        @(posedge CLK); #1;
        idle();
        chk_cnt(32'd4, 32'd1, "cnt_totals");
`endif

        repeat (2) @(posedge CLK);
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
